// File: rtl/bfg_mux_test_sequencer_if.sv
// Bus between the mux comparison sequencer and its harness/mux instances.
// master = sequencer side, slave = harness side (start, mux outputs, results).
interface bfg_mux_test_sequencer_if;
  logic       start;
  logic [5:0] vec;
  logic       gf_out;
  logic       bfg_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] gf_err_count;
  logic [6:0] bfg_err_count;
  logic       first_fail_valid;
  logic [5:0] first_fail_vec;
  logic [1:0] first_fail_src;

  modport master (
    input  start, gf_out, bfg_out,
    output vec, busy, done, pass, gf_err_count, bfg_err_count,
           first_fail_valid, first_fail_vec, first_fail_src
  );

  modport slave (
    output start, gf_out, bfg_out,
    input  vec, busy, done, pass, gf_err_count, bfg_err_count,
           first_fail_valid, first_fail_vec, first_fail_src
  );
endinterface

// File: rtl/bfg_mux_test_sequencer.sv
// Sweeps all 64 {s1,s0,i3,i2,i1,i0} vectors into two 4:1 muxes and checks
// both outputs against a golden select, counting errors and capturing the first failure.
module bfg_mux_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  bfg_mux_test_sequencer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [5:0] vec_q, vec_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [6:0] gf_cnt_q, gf_cnt_d;
  logic [6:0] bfg_cnt_q, bfg_cnt_d;
  logic       pass_q, pass_d;
  logic       ff_valid_q, ff_valid_d;
  logic [5:0] ff_vec_q, ff_vec_d;
  logic [1:0] ff_src_q, ff_src_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic exp_bit;
  logic gf_err;
  logic bfg_err;

  always_comb begin
    exp_bit = vec_q[{vec_q[5], vec_q[4]}];
    gf_err  = bus.gf_out ^ exp_bit;
    bfg_err = bus.bfg_out ^ exp_bit;

    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    gf_cnt_d     = gf_cnt_q;
    bfg_cnt_d    = bfg_cnt_q;
    pass_d       = pass_q;
    ff_valid_d   = ff_valid_q;
    ff_vec_d     = ff_vec_q;
    ff_src_d     = ff_src_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = SETTLE;
          vec_d        = '0;
          settle_cnt_d = SETTLE_INIT;
          gf_cnt_d     = '0;
          bfg_cnt_d    = '0;
          pass_d       = 1'b0;
          ff_valid_d   = 1'b0;
          ff_vec_d     = '0;
          ff_src_d     = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        gf_cnt_d  = gf_cnt_q + 7'(gf_err);
        bfg_cnt_d = bfg_cnt_q + 7'(bfg_err);
        if ((gf_err || bfg_err) && !ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_vec_d   = vec_q;
          ff_src_d   = {bfg_err, gf_err};
        end
        // pass uses the post-update counts so results are valid in the done cycle
        if (vec_q == 6'd63) begin
          state_d = DONE;
          pass_d  = (gf_cnt_d == 7'd0) && (bfg_cnt_d == 7'd0);
        end else begin
          state_d      = SETTLE;
          vec_d        = vec_q + 6'd1;
          settle_cnt_d = SETTLE_INIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_cnt_q <= '0;
      gf_cnt_q     <= '0;
      bfg_cnt_q    <= '0;
      pass_q       <= 1'b0;
      ff_valid_q   <= 1'b0;
      ff_vec_q     <= '0;
      ff_src_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      gf_cnt_q     <= gf_cnt_d;
      bfg_cnt_q    <= bfg_cnt_d;
      pass_q       <= pass_d;
      ff_valid_q   <= ff_valid_d;
      ff_vec_q     <= ff_vec_d;
      ff_src_q     <= ff_src_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.vec              = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.gf_err_count     = gf_cnt_q;
  assign bus.bfg_err_count    = bfg_cnt_q;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign bus.first_fail_src   = ff_src_q;

endmodule

// File: tb/tb_bfg_mux_test_sequencer.sv
// Scoreboard bench: three sequencers (N=0,2,15) driven by ideal/faulty mux models;
// expected sweep results are queued at start and checked when done pulses.
module tb_bfg_mux_test_sequencer;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [6:0] gf_cnt;
    logic [6:0] bfg_cnt;
    logic       ff_valid;
    logic [5:0] ff_vec;
    logic [1:0] ff_src;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   mode = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  int   start_cyc [3];
  bit   track [3];

  bfg_mux_test_sequencer_if if0 ();
  bfg_mux_test_sequencer_if if2 ();
  bfg_mux_test_sequencer_if if15 ();

  bfg_mux_test_sequencer #(.SETTLE_CYCLES(0))  dut0  (.clk(clk), .rst(rst), .bus(if0.master));
  bfg_mux_test_sequencer #(.SETTLE_CYCLES(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.master));
  bfg_mux_test_sequencer #(.SETTLE_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(if15.master));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mux models: 0 = both ideal, 1 = bfg stuck-at-0, 2 = gf inverted and bfg stuck-at-1
  function automatic logic [1:0] muxModel(input logic [5:0] v, input int m);
    logic g;
    g = v[{v[5], v[4]}];
    case (m)
      1:       muxModel = {1'b0, g};
      2:       muxModel = {1'b1, ~g};
      default: muxModel = {g, g};
    endcase
  endfunction

  assign {if0.bfg_out, if0.gf_out}   = muxModel(if0.vec, mode);
  assign {if2.bfg_out, if2.gf_out}   = muxModel(if2.vec, mode);
  assign {if15.bfg_out, if15.gf_out} = muxModel(if15.vec, mode);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed sweep results for each mux model
  function automatic exp_t expFor(input int m, input int n, input int s);
    exp_t e;
    e.done_cyc = s + 64 * (n + 2) + 1;
    case (m)
      1: begin
        e.pass = 1'b0; e.gf_cnt = 7'd0; e.bfg_cnt = 7'd32;
        e.ff_valid = 1'b1; e.ff_vec = 6'h01; e.ff_src = 2'b10;
      end
      2: begin
        e.pass = 1'b0; e.gf_cnt = 7'd64; e.bfg_cnt = 7'd32;
        e.ff_valid = 1'b1; e.ff_vec = 6'h00; e.ff_src = 2'b11;
      end
      default: begin
        e.pass = 1'b1; e.gf_cnt = 7'd0; e.bfg_cnt = 7'd0;
        e.ff_valid = 1'b0; e.ff_vec = 6'h00; e.ff_src = 2'b00;
      end
    endcase
    return e;
  endfunction

  function automatic int sbSize(input int idx);
    case (idx)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sbPush(input int idx, input exp_t e);
    case (idx)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sbPop(input int idx, output exp_t e);
    case (idx)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic setStart(input int idx, input logic v);
    case (idx)
      0:       if0.start = v;
      1:       if2.start = v;
      default: if15.start = v;
    endcase
  endtask

  function automatic int nOf(input int idx);
    case (idx)
      0:       return 0;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  task automatic applyStimulus(input int idx, input int m);
    @(negedge clk);
    mode = m;
    setStart(idx, 1'b1);
    start_cyc[idx] = cyc;
    track[idx] = 1'b1;
    sbPush(idx, expFor(m, nOf(idx), cyc));
    @(negedge clk);
    setStart(idx, 1'b0);
  endtask

  task automatic monitorStep(input int idx, input logic busy, input logic done,
                             input logic [5:0] vec, input logic pass,
                             input logic [6:0] gfc, input logic [6:0] bfgc,
                             input logic ffv, input logic [5:0] ffvec, input logic [1:0] ffsrc);
    exp_t e;
    int   n;
    int   k;
    int   last;
    n = nOf(idx);
    last = 64 * (n + 2);
    if (track[idx]) begin
      k = cyc - start_cyc[idx];
      if (k >= 1 && k <= last) begin
        checkOutput($sformatf("n%0d_busy_c%0d", n, k), 32'(busy), 32'd1);
        checkOutput($sformatf("n%0d_vec_c%0d", n, k), 32'(vec), 32'((k - 1) / (n + 2)));
      end else if (k > last) begin
        track[idx] = 1'b0;
      end
    end
    if (done) begin
      if (sbSize(idx) == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL n%0d_unexpected_done: got done=1 at cycle %0d, expected no done", n, cyc);
      end else begin
        sbPop(idx, e);
        checkOutput($sformatf("n%0d_done_cycle", n), 32'(cyc - e.done_cyc + 1000), 32'd1000);
        checkOutput($sformatf("n%0d_busy_at_done", n), 32'(busy), 32'd0);
        checkOutput($sformatf("n%0d_vec_at_done", n), 32'(vec), 32'd63);
        checkOutput($sformatf("n%0d_pass", n), 32'(pass), 32'(e.pass));
        checkOutput($sformatf("n%0d_gf_err_count", n), 32'(gfc), 32'(e.gf_cnt));
        checkOutput($sformatf("n%0d_bfg_err_count", n), 32'(bfgc), 32'(e.bfg_cnt));
        checkOutput($sformatf("n%0d_first_fail_valid", n), 32'(ffv), 32'(e.ff_valid));
        checkOutput($sformatf("n%0d_first_fail_vec", n), 32'(ffvec), 32'(e.ff_vec));
        checkOutput($sformatf("n%0d_first_fail_src", n), 32'(ffsrc), 32'(e.ff_src));
      end
    end
  endtask

  always @(negedge clk) if (!rst) begin
    monitorStep(0, if0.busy, if0.done, if0.vec, if0.pass, if0.gf_err_count, if0.bfg_err_count,
                if0.first_fail_valid, if0.first_fail_vec, if0.first_fail_src);
    monitorStep(1, if2.busy, if2.done, if2.vec, if2.pass, if2.gf_err_count, if2.bfg_err_count,
                if2.first_fail_valid, if2.first_fail_vec, if2.first_fail_src);
    monitorStep(2, if15.busy, if15.done, if15.vec, if15.pass, if15.gf_err_count, if15.bfg_err_count,
                if15.first_fail_valid, if15.first_fail_vec, if15.first_fail_src);
  end

  task automatic checkResetOne(input string tag, input logic [5:0] vec, input logic busy,
                               input logic done, input logic pass, input logic [6:0] gfc,
                               input logic [6:0] bfgc, input logic ffv, input logic [5:0] ffvec,
                               input logic [1:0] ffsrc);
    checkOutput({tag, "_vec"}, 32'(vec), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
    checkOutput({tag, "_gf_cnt"}, 32'(gfc), 32'd0);
    checkOutput({tag, "_bfg_cnt"}, 32'(bfgc), 32'd0);
    checkOutput({tag, "_ff_valid"}, 32'(ffv), 32'd0);
    checkOutput({tag, "_ff_vec"}, 32'(ffvec), 32'd0);
    checkOutput({tag, "_ff_src"}, 32'(ffsrc), 32'd0);
  endtask

  task automatic checkResetAll(input string tag);
    checkResetOne({tag, "_n0"}, if0.vec, if0.busy, if0.done, if0.pass, if0.gf_err_count,
                  if0.bfg_err_count, if0.first_fail_valid, if0.first_fail_vec, if0.first_fail_src);
    checkResetOne({tag, "_n2"}, if2.vec, if2.busy, if2.done, if2.pass, if2.gf_err_count,
                  if2.bfg_err_count, if2.first_fail_valid, if2.first_fail_vec, if2.first_fail_src);
    checkResetOne({tag, "_n15"}, if15.vec, if15.busy, if15.done, if15.pass, if15.gf_err_count,
                  if15.bfg_err_count, if15.first_fail_valid, if15.first_fail_vec, if15.first_fail_src);
  endtask

  task automatic waitDrain(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sbSize(0) == 0 && sbSize(1) == 0 && sbSize(2) == 0) break;
    end
    if (i >= bound) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending sweeps after %0d cycles, expected 0",
               sbSize(0) + sbSize(1) + sbSize(2), bound);
      sb0.delete(); sb1.delete(); sb2.delete();
    end
  endtask

  task automatic waitVec2(input logic [5:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (if2.vec == target && if2.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_vec_%0d: got vec=%0d, expected to reach %0d", target, if2.vec, target);
    end
  endtask

  initial begin
    bit ok;
    if0.start = 1'b0;
    if2.start = 1'b0;
    if15.start = 1'b0;
    track[0] = 1'b0; track[1] = 1'b0; track[2] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetAll("reset");

    $display("[TB] ideal models, N=2");
    applyStimulus(1, 0);
    waitDrain(400);
    repeat (3) @(negedge clk);
    checkOutput("n2_vec_hold", 32'(if2.vec), 32'd63);
    checkOutput("n2_pass_hold", 32'(if2.pass), 32'd1);
    checkOutput("n2_busy_idle", 32'(if2.busy), 32'd0);

    $display("[TB] bfg stuck-at-0, N=2");
    applyStimulus(1, 1);
    waitDrain(400);

    $display("[TB] gf inverted, bfg stuck-at-1, N=2");
    applyStimulus(1, 2);
    waitDrain(400);
    repeat (2) @(negedge clk);
    checkOutput("n2_gf_cnt_hold", 32'(if2.gf_err_count), 32'd64);

    $display("[TB] ideal models, N=0 and N=15");
    applyStimulus(0, 0);
    waitDrain(300);
    applyStimulus(2, 0);
    waitDrain(1300);

    $display("[TB] start pulsed during busy at vector 10");
    applyStimulus(1, 0);
    waitVec2(6'd10, ok);
    if (ok) begin
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
    end
    waitDrain(400);

    $display("[TB] reset at vector 40 of a failing sweep");
    applyStimulus(1, 1);
    waitVec2(6'd40, ok);
    rst = 1'b1;
    track[1] = 1'b0;
    sb1.delete();
    @(negedge clk);
    rst = 1'b0;
    checkResetAll("midreset");
    applyStimulus(1, 1);
    waitDrain(400);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bfg_mux_test_sequencer.md
# bfg_mux_test_sequencer

Self-checking stimulus sequencer for the mux comparison test. It drives the shared inputs of the standard-cell `mux4_1` and the BFG-generated `gf180mcu_mux` with all 64 combinations of {s1,s0,i3,i2,i1,i0}. For each vector it waits a programmable settle time, then samples both mux outputs. Each output is checked against a golden 4:1 model, with per-mux error counts and first-failure capture. The block sits between the test harness (start/result registers) and the two mux instances.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles a vector is held before its outputs are sampled; legal range 0..15.
- `clk`  in  1  sole clock; every flop is rising-edge `clk`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `vec`  out  6  stimulus {s1,s0,i3,i2,i1,i0}, registered; the harness inverts s0/s1 to form s0b/s1b.
- `gf_out`  in  1  standard-cell mux output.
- `bfg_out`  in  1  BFG mux output.
- `busy`  out  1  high while a sweep runs.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  high when the last sweep had zero errors on both muxes.
- `gf_err_count`  out  7  gf_out mismatches vs golden in the last sweep.
- `bfg_err_count`  out  7  bfg_out mismatches vs golden.
- `first_fail_valid`  out  1  at least one mismatch was seen this sweep.
- `first_fail_vec`  out  6  vector value at the first mismatching sample.
- `first_fail_src`  out  2  {bfg_err, gf_err} flags at that first mismatch.

## Operation
- Golden value: `exp = vec[{vec[5],vec[4]}]`, i.e. selects i0..i3 via {s1,s0}.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE → SETTLE on `start`. This transition sets vec=0, settle_cnt=SETTLE_CYCLES, and clears both err counts, pass, first_fail_valid, first_fail_vec and first_fail_src.
- SETTLE: if settle_cnt==0, go to SAMPLE; otherwise decrement settle_cnt.
- SAMPLE:
  - gf_err = gf_out^exp and bfg_err = bfg_out^exp.
  - Increment each count whose err is 1.
  - If (gf_err|bfg_err) and !first_fail_valid, capture vec and {bfg_err,gf_err}, and set first_fail_valid.
  - If vec==63, go to DONE. Otherwise vec<=vec+1, settle_cnt<=SETTLE_CYCLES, and go to SETTLE.
- DONE: done=1 for exactly this cycle. pass <= (both counts zero, including the final sample's update). Then go to IDLE.
- `busy` = state∈{SETTLE,SAMPLE}.
- `vec` holds its last value (63) in IDLE after a sweep. The results registers hold until the next `start`.
- `start` in SETTLE, SAMPLE or DONE is ignored. It is not queued.
- Counts max out at 64, so 7 bits never wrap and no saturation logic is needed.
- Inputs are sampled only in SAMPLE. Values outside SAMPLE are don't-care.

## Timing
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, both counts=0, first_fail_valid=0, first_fail_vec=0, first_fail_src=0.
- Reset mid-sweep returns every output to its reset value on the next edge. The sweep is abandoned.
- Per vector: SETTLE_CYCLES+1 cycles in SETTLE, then 1 cycle in SAMPLE, for a total of N+2 cycles with N=SETTLE_CYCLES.
- A vector is stable on `vec` for N+1 full cycles before the SAMPLE edge.
- With `start` seen at edge E0:
  - busy is high in cycles 1..64·(N+2).
  - done is high in cycle 64·(N+2)+1.
  - For N=2: busy spans cycles 1..256, done fires in cycle 257.
- Results are valid in the `done` cycle and remain stable afterwards.
- Fastest restart: `start` asserted in the cycle after `done` is accepted.

## Test plan
- Both mux models ideal, N=2 → done in cycle 257; pass=1; both counts=0; first_fail_valid=0; vec=63 afterwards.
- bfg_out stuck-at-0, gf ideal → bfg_err_count=32, gf_err_count=0, pass=0, first_fail_vec=6'h01, first_fail_src=2'b10.
- gf_out inverted, bfg stuck-at-1 → gf_err_count=64, bfg_err_count=32, first_fail_vec=6'h00, first_fail_src=2'b11.
- N=0 and N=15 with ideal models → done in cycles 129 and 1089 respectively. Check vec increments every N+2 cycles.
- Pulse `start` during busy at vector 10 → no restart; counts and timing match an undisturbed run.
- Assert `rst` for one cycle at vector 40 of a failing run → all outputs return to reset values. A following `start` produces a clean full sweep with the expected counts.
